// File: rtl/hdmi_pkg.sv
// Shared types, TMDS code constants and 640x480@60 timing defaults for the HDMI source.
// Pure declarations and helper functions; no state, no flow control.
package hdmi_pkg;

  localparam int FRAME_WIDTH_DEF   = 800;
  localparam int FRAME_HEIGHT_DEF  = 525;
  localparam int SCREEN_WIDTH_DEF  = 640;
  localparam int SCREEN_HEIGHT_DEF = 480;
  localparam int HSYNC_START_DEF   = 16;
  localparam int HSYNC_WIDTH_DEF   = 96;
  localparam int VSYNC_START_DEF   = 10;
  localparam int VSYNC_WIDTH_DEF   = 2;

  // Fixed per-line data-island placement (cx values)
  localparam logic [9:0] DI_PRE_X0   = 10'd2;
  localparam logic [9:0] DI_GUARD_X0 = 10'd10;
  localparam logic [9:0] DI_DATA_X0  = 10'd12;
  localparam logic [9:0] DI_TRAIL_X0 = 10'd44;
  localparam logic [9:0] DI_END_X0   = 10'd46;

  typedef enum logic [2:0] {
    CONTROL,
    DI_PREAMBLE,
    DI_GUARD,
    DI_DATA,
    VID_PREAMBLE,
    VID_GUARD,
    VIDEO
  } period_t;

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  localparam logic [9:0] DI_GUARD_CODE  = 10'b0100110011;
  localparam logic [9:0] VID_GUARD_CH02 = 10'b1011001100;
  localparam logic [9:0] VID_GUARD_CH1  = 10'b0100110011;

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    unique case (c)
      2'b00:   return CTL_00;
      2'b01:   return CTL_01;
      2'b10:   return CTL_10;
      default: return CTL_11;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    unique case (d)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // First DVI stage: transition-minimised word, bit 8 set when XOR was used
  function automatic logic [8:0] tmds_min(input logic [7:0] d);
    logic [8:0] q;
    logic       xn;
    xn   = (ones8(d) > 4'd4) || (ones8(d) == 4'd4 && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

endpackage

// File: rtl/hdmi_tmds_frame_gen_tmds_channel.sv
// One TMDS lane: selects control/TERC4/guard/video character and owns the running disparity.
// Latency 1 cycle (registered character); free-running, no backpressure.
module tmds_channel
  import hdmi_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  period_t    mode,
  input  logic [7:0] vid_dat,
  input  logic [1:0] ctl,
  input  logic [3:0] terc4_dat,
  output logic [9:0] tmds
);

  logic [8:0]        q_m;
  logic [3:0]        n1_q;
  logic signed [5:0] bal_w;
  logic signed [4:0] bal;
  logic signed [4:0] disp;
  logic signed [4:0] disp_nxt;
  logic [9:0]        vid_code;
  logic [9:0]        code_nxt;

  always_comb begin
    q_m   = tmds_min(vid_dat);
    n1_q  = ones8(q_m[7:0]);
    // ones minus zeros of the 8 data bits, range -8..+8
    bal_w = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    bal   = bal_w[4:0];
    if (disp == 5'sd0 || bal == 5'sd0) begin
      vid_code = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      disp_nxt = q_m[8] ? disp + bal : disp - bal;
    end else if (disp[4] == bal[4]) begin
      vid_code = {1'b1, q_m[8], ~q_m[7:0]};
      disp_nxt = disp - bal + (q_m[8] ? 5'sd2 : 5'sd0);
    end else begin
      vid_code = {1'b0, q_m[8], q_m[7:0]};
      disp_nxt = disp + bal - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_comb begin
    code_nxt = ctl_code(ctl);
    unique case (mode)
      VIDEO:     code_nxt = vid_code;
      DI_DATA:   code_nxt = terc4(terc4_dat);
      DI_GUARD:  code_nxt = (CHANNEL == 0) ? terc4(terc4_dat) : DI_GUARD_CODE;
      VID_GUARD: code_nxt = (CHANNEL == 1) ? VID_GUARD_CH1 : VID_GUARD_CH02;
      default:   code_nxt = ctl_code(ctl);
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds <= CTL_00;
      disp <= 5'sd0;
    end else begin
      tmds <= code_nxt;
      disp <= (mode == VIDEO) ? disp_nxt : 5'sd0;
    end
  end

endmodule

// File: rtl/hdmi_tmds_frame_gen.sv
// HDMI 640x480@60 source: raster counters, sync, period decode and three TMDS lanes with a test pattern.
// tmds lags cx/cy by 1 cycle; free-running, no backpressure toward the serializer.
module hdmi_tmds_frame_gen
  import hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH   = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT  = FRAME_HEIGHT_DEF,
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int HSYNC_START   = HSYNC_START_DEF,
  parameter int HSYNC_WIDTH   = HSYNC_WIDTH_DEF,
  parameter int VSYNC_START   = VSYNC_START_DEF,
  parameter int VSYNC_WIDTH   = VSYNC_WIDTH_DEF
) (
  input  logic            clk_pixel,
  input  logic            reset,
  output logic [2:0][9:0] tmds,
  output logic [9:0]      cx,
  output logic [9:0]      cy,
  output logic            hsync,
  output logic            vsync,
  output logic [9:0]      frame_width,
  output logic [9:0]      frame_height
);

  localparam logic [9:0] CX_LAST      = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0] CY_LAST      = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] VID_X0       = 10'(FRAME_WIDTH - SCREEN_WIDTH);
  localparam logic [9:0] VID_Y0       = 10'(FRAME_HEIGHT - SCREEN_HEIGHT);
  localparam logic [9:0] VID_GUARD_X0 = 10'(FRAME_WIDTH - SCREEN_WIDTH - 2);
  localparam logic [9:0] VID_PRE_X0   = 10'(FRAME_WIDTH - SCREEN_WIDTH - 10);
  localparam logic [9:0] HS_X0        = 10'(HSYNC_START);
  localparam logic [9:0] HS_X1        = 10'(HSYNC_START + HSYNC_WIDTH);
  localparam logic [9:0] VS_Y0        = 10'(VSYNC_START);
  localparam logic [9:0] VS_Y1        = 10'(VSYNC_START + VSYNC_WIDTH);

  period_t    period;
  logic       active_y;
  logic [1:0] ctl0, ctl1, ctl2;
  logic [3:0] terc0;
  logic [7:0] red, green;
  logic [9:0] tmds0, tmds1, tmds2;

  assign frame_width  = 10'(FRAME_WIDTH);
  assign frame_height = 10'(FRAME_HEIGHT);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == CX_LAST) begin
      cx <= '0;
      cy <= (cy == CY_LAST) ? 10'd0 : cy + 10'd1;
    end else begin
      cx <= cx + 10'd1;
    end
  end

  assign hsync    = ~(cx >= HS_X0 && cx < HS_X1);
  assign vsync    = ~(cy >= VS_Y0 && cy < VS_Y1);
  assign active_y = (cy >= VID_Y0);

  always_comb begin
    period = CONTROL;
    if (cx >= DI_PRE_X0 && cx < DI_GUARD_X0)        period = DI_PREAMBLE;
    else if (cx >= DI_GUARD_X0 && cx < DI_DATA_X0)  period = DI_GUARD;
    else if (cx >= DI_DATA_X0 && cx < DI_TRAIL_X0)  period = DI_DATA;
    else if (cx >= DI_TRAIL_X0 && cx < DI_END_X0)   period = DI_GUARD;
    else if (active_y) begin
      if (cx >= VID_X0)            period = VIDEO;
      else if (cx >= VID_GUARD_X0) period = VID_GUARD;
      else if (cx >= VID_PRE_X0)   period = VID_PREAMBLE;
    end
  end

  // Sync rides on lane 0; the null packet header bit 3 is clear only on its first character
  assign ctl0  = {vsync, hsync};
  assign ctl1  = (period == DI_PREAMBLE || period == VID_PREAMBLE) ? 2'b01 : 2'b00;
  assign ctl2  = (period == DI_PREAMBLE) ? 2'b01 : 2'b00;
  assign terc0 = (period == DI_DATA) ? {cx != DI_DATA_X0, 1'b0, vsync, hsync}
                                     : {2'b11, vsync, hsync};

  assign red   = cx[7:0] - VID_X0[7:0];
  assign green = cy[7:0] - VID_Y0[7:0];

  tmds_channel #(.CHANNEL(0)) u_ch0 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .mode      (period),
    .vid_dat   (8'h80),
    .ctl       (ctl0),
    .terc4_dat (terc0),
    .tmds      (tmds0)
  );

  tmds_channel #(.CHANNEL(1)) u_ch1 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .mode      (period),
    .vid_dat   (green),
    .ctl       (ctl1),
    .terc4_dat (4'b0000),
    .tmds      (tmds1)
  );

  tmds_channel #(.CHANNEL(2)) u_ch2 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .mode      (period),
    .vid_dat   (red),
    .ctl       (ctl2),
    .terc4_dat (4'b0000),
    .tmds      (tmds2)
  );

  assign tmds = {tmds2, tmds1, tmds0};

endmodule

// File: tb/tb_hdmi_tmds_frame_gen.sv
// Scoreboard bench: a short-frame instance is checked every cycle against a raster/TMDS model;
// a default-parameter instance runs alongside for the constant outputs and counter reach.
module tb_hdmi_tmds_frame_gen;

  localparam int FW  = 800;
  localparam int FH  = 24;
  localparam int SW  = 640;
  localparam int SH  = 4;
  localparam int VY0 = FH - SH;

  localparam logic [9:0] CTL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                         10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  localparam logic [9:0] DI_GB = 10'b0100110011;
  localparam logic [9:0] VG_02 = 10'b1011001100;
  localparam logic [9:0] VG_1  = 10'b0100110011;

  typedef struct {
    logic       vid;
    logic [9:0] c0, c1, c2;
    logic [7:0] r, g;
    int         x, y;
  } sb_t;

  logic            clk_pixel = 1'b0;
  logic            reset;
  logic [2:0][9:0] tmds, d_tmds;
  logic [9:0]      cx, cy, d_cx, d_cy;
  logic            hsync, vsync, d_hsync, d_vsync;
  logic [9:0]      frame_width, frame_height, d_fw, d_fh;

  int  n_chk = 0;
  int  n_bad = 0;
  int  mcx, mcy;
  int  rd [3];
  sb_t q [$];

  always #5 clk_pixel = ~clk_pixel;

  hdmi_tmds_frame_gen #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .tmds(tmds), .cx(cx), .cy(cy),
    .hsync(hsync), .vsync(vsync), .frame_width(frame_width), .frame_height(frame_height)
  );

  hdmi_tmds_frame_gen dut_def (
    .clk_pixel(clk_pixel), .reset(reset), .tmds(d_tmds), .cx(d_cx), .cy(d_cy),
    .hsync(d_hsync), .vsync(d_vsync), .frame_width(d_fw), .frame_height(d_fh)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (model cx=%0d cy=%0d)", tag, got, exp, mcx, mcy);
    end
  endtask

  function automatic sb_t model(input int x, input int y);
    sb_t  e;
    logic hs, vs;
    hs    = !(x >= 16 && x < 112);
    vs    = !(y >= 10 && y < 12);
    e.vid = 1'b0;
    e.x   = x;
    e.y   = y;
    e.r   = 8'(x - 160);
    e.g   = 8'(y - VY0);
    e.c0  = CTL_TAB[{vs, hs}];
    e.c1  = CTL_TAB[0];
    e.c2  = CTL_TAB[0];
    if (x >= 2 && x < 10) begin
      e.c1 = CTL_TAB[1];
      e.c2 = CTL_TAB[1];
    end else if ((x >= 10 && x < 12) || (x >= 44 && x < 46)) begin
      e.c0 = TERC4_TAB[{2'b11, vs, hs}];
      e.c1 = DI_GB;
      e.c2 = DI_GB;
    end else if (x >= 12 && x < 44) begin
      e.c0 = TERC4_TAB[{x != 12, 1'b0, vs, hs}];
      e.c1 = TERC4_TAB[0];
      e.c2 = TERC4_TAB[0];
    end else if (y >= VY0) begin
      if (x >= 160) e.vid = 1'b1;
      else if (x >= 158) begin
        e.c0 = VG_02;
        e.c1 = VG_1;
        e.c2 = VG_02;
      end else if (x >= 150) e.c1 = CTL_TAB[1];
    end
    return e;
  endfunction

  function automatic logic [7:0] dvi_dec(input logic [9:0] c);
    logic [7:0] d, o;
    d    = c[9] ? ~c[7:0] : c[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic sample_cycle();
    sb_t        e;
    logic [9:0] ch [3];
    check_val("cx", 32'(cx), 32'(mcx));
    check_val("cy", 32'(cy), 32'(mcy));
    check_val("hsync", 32'(hsync), 32'(!(mcx >= 16 && mcx < 112)));
    check_val("vsync", 32'(vsync), 32'(!(mcy >= 10 && mcy < 12)));
    if (q.size() > 0) begin
      e     = q.pop_front();
      ch[0] = tmds[0];
      ch[1] = tmds[1];
      ch[2] = tmds[2];
      if (e.vid) begin
        check_val($sformatf("vid_r x=%0d y=%0d", e.x, e.y), 32'(dvi_dec(ch[2])), 32'(e.r));
        check_val($sformatf("vid_g x=%0d y=%0d", e.x, e.y), 32'(dvi_dec(ch[1])), 32'(e.g));
        check_val($sformatf("vid_b x=%0d y=%0d", e.x, e.y), 32'(dvi_dec(ch[0])), 32'h80);
        for (int k = 0; k < 3; k++) begin
          rd[k] += 2 * $countones(ch[k]) - 10;
          check_val($sformatf("disp%0d x=%0d y=%0d", k, e.x, e.y),
                    32'(rd[k] >= -8 && rd[k] <= 8), 32'd1);
        end
      end else begin
        check_val($sformatf("ch0 x=%0d y=%0d", e.x, e.y), 32'(ch[0]), 32'(e.c0));
        check_val($sformatf("ch1 x=%0d y=%0d", e.x, e.y), 32'(ch[1]), 32'(e.c1));
        check_val($sformatf("ch2 x=%0d y=%0d", e.x, e.y), 32'(ch[2]), 32'(e.c2));
        for (int k = 0; k < 3; k++) rd[k] = 0;
      end
    end
    q.push_back(model(mcx, mcy));
  endtask

  task automatic advance();
    if (mcx == FW - 1) begin
      mcx = 0;
      mcy = (mcy == FH - 1) ? 0 : mcy + 1;
    end else begin
      mcx++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_cx"}, 32'(cx), 32'd0);
    check_val({tag, "_cy"}, 32'(cy), 32'd0);
    check_val({tag, "_tmds0"}, 32'(tmds[0]), 32'(CTL_TAB[0]));
    check_val({tag, "_tmds1"}, 32'(tmds[1]), 32'(CTL_TAB[0]));
    check_val({tag, "_tmds2"}, 32'(tmds[2]), 32'(CTL_TAB[0]));
    check_val({tag, "_def_cx"}, 32'(d_cx), 32'd0);
    check_val({tag, "_def_cy"}, 32'(d_cy), 32'd0);
    check_val({tag, "_def_tmds"}, 32'(d_tmds), 32'({3{CTL_TAB[0]}}));
  endtask

  initial begin
    reset = 1'b1;
    mcx   = 0;
    mcy   = 0;
    for (int k = 0; k < 3; k++) rd[k] = 0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_reset_state("rst");
    check_val("frame_width", 32'(frame_width), 32'(FW));
    check_val("frame_height", 32'(frame_height), 32'(FH));
    check_val("def_frame_width", 32'(d_fw), 32'd800);
    check_val("def_frame_height", 32'(d_fh), 32'd525);
    check_val("def_hsync_rst", 32'(d_hsync), 32'd1);
    check_val("def_vsync_rst", 32'(d_vsync), 32'd1);
    reset = 1'b0;

    // One full short frame, then into the second frame up to an active video pixel
    for (int i = 0; i < FW * FH + 21 * FW + 300; i++) begin
      sample_cycle();
      if (i == FW * FH) begin
        check_val("def_cx_at_wrap", 32'(d_cx), 32'd0);
        check_val("def_cy_at_wrap", 32'(d_cy), 32'(FH));
      end
      @(negedge clk_pixel);
      advance();
    end
    sample_cycle();
    check_val("pre_rst_cx", 32'(cx), 32'd300);
    check_val("pre_rst_def_cy", 32'(d_cy), 32'(FH + 21));

    reset = 1'b1;
    @(negedge clk_pixel);
    check_reset_state("midrst");
    reset = 1'b0;
    q.delete();
    mcx = 0;
    mcy = 0;
    for (int k = 0; k < 3; k++) rd[k] = 0;
    for (int i = 0; i < 2 * FW; i++) begin
      sample_cycle();
      @(negedge clk_pixel);
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
